// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Program counter and fetch sequencer with branch/jump redirect,
//            post-redirect fetch bubbles and halt/resume. Optional link
//            register enabled by defining LINK_REG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int PC_WIDTH      = 15,
  parameter int RESET_PC      = 0,
  parameter int PC_STEP       = 2,
  parameter int BUBBLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall_i,
  input  logic                fetch_ready,
  input  logic                branch_req,
  input  logic [31:0]         branch_offset,
  input  logic                jump_req,
  input  logic [31:0]         jump_target,
  input  logic                halt_req,
  input  logic                resume,
`ifdef LINK_REG_EN
  input  logic                link_req,
  output logic [PC_WIDTH-1:0] link_pc,
`endif
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                fetch_valid,
  output logic                redirect_busy,
  output logic                halted
);

  localparam logic [1:0] c_st_run    = 2'd0;
  localparam logic [1:0] c_st_bubble = 2'd1;
  localparam logic [1:0] c_st_halt   = 2'd2;

  localparam logic [PC_WIDTH-1:0] c_reset_pc    = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] c_pc_step     = PC_WIDTH'(PC_STEP);
  localparam logic [2:0]          c_bubble_init = 3'(BUBBLE_CYCLES - 1);

  logic [1:0]          r_state;
  logic [1:0]          w_state_next;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_next;
  logic [2:0]          r_cnt;
  logic [2:0]          w_cnt_next;

  // Operands are word indices; scaling by 2 drops the top bit before truncation.
  logic [31:0]         w_jump_shift;
  logic [31:0]         w_branch_shift;
  logic [PC_WIDTH-1:0] w_jump_pc;
  logic [PC_WIDTH-1:0] w_branch_pc;
  logic [PC_WIDTH-1:0] w_step_pc;
  logic                w_unused;

  assign w_jump_shift   = {jump_target[30:0], 1'b0};
  assign w_branch_shift = {branch_offset[30:0], 1'b0};
  assign w_jump_pc      = w_jump_shift[PC_WIDTH-1:0];
  assign w_branch_pc    = r_pc + w_branch_shift[PC_WIDTH-1:0];
  assign w_step_pc      = r_pc + c_pc_step;
  assign w_unused       = ^{w_jump_shift[31:PC_WIDTH], w_branch_shift[31:PC_WIDTH],
                            jump_target[31], branch_offset[31]};

`ifdef LINK_REG_EN
  logic [PC_WIDTH-1:0] r_link;
  logic [PC_WIDTH-1:0] w_link_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_st_run;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc  <= c_reset_pc;
      r_cnt <= 3'd0;
`ifdef LINK_REG_EN
      r_link <= '0;
`endif
    end else begin
      r_pc  <= w_pc_next;
      r_cnt <= w_cnt_next;
`ifdef LINK_REG_EN
      r_link <= w_link_next;
`endif
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_cnt_next   = r_cnt;
`ifdef LINK_REG_EN
    w_link_next  = r_link;
`endif
    case (r_state)
      c_st_run: begin
        if (halt_req) begin
          w_state_next = c_st_halt;
        end else if (jump_req) begin
          w_pc_next    = w_jump_pc;
          w_cnt_next   = c_bubble_init;
          w_state_next = c_st_bubble;
`ifdef LINK_REG_EN
          if (link_req) begin
            w_link_next = w_step_pc;
          end
`endif
        end else if (branch_req) begin
          w_pc_next    = w_branch_pc;
          w_cnt_next   = c_bubble_init;
          w_state_next = c_st_bubble;
        end else if (fetch_ready && !stall_i) begin
          w_pc_next = w_step_pc;
        end
      end
      c_st_bubble: begin
        if (halt_req) begin
          w_state_next = c_st_halt;
          w_cnt_next   = 3'd0;
        end else if (r_cnt == 3'd0) begin
          w_state_next = c_st_run;
        end else begin
          w_cnt_next = r_cnt - 3'd1;
        end
      end
      c_st_halt: begin
        if (resume) begin
          w_state_next = c_st_run;
        end
      end
      default: begin
        w_state_next = c_st_run;
      end
    endcase
  end

  // Flags are forced low while reset is applied, independent of held state.
  always_comb begin
    pc_out        = r_pc;
    fetch_valid   = ~reset & (r_state == c_st_run);
    redirect_busy = ~reset & (r_state == c_st_bubble);
    halted        = ~reset & (r_state == c_st_halt);
  end

`ifdef LINK_REG_EN
  assign link_pc = r_link;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Self-checking bench for pc_sequencer (vector table + directed
//            sequence on a BUBBLE_CYCLES=3 instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  typedef struct {
    logic        rst, stall, fr, br;
    logic [31:0] boff;
    logic        jr;
    logic [31:0] jt;
    logic        hr, rs, lk;
    logic [14:0] pc;
    logic        fv, rb, h;
    logic [14:0] link;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic        reset = 1'b1, stall_i = 1'b0, fetch_ready = 1'b0, branch_req = 1'b0;
  logic [31:0] branch_offset = '0, jump_target = '0;
  logic        jump_req = 1'b0, halt_req = 1'b0, resume = 1'b0, link_req = 1'b0;
  logic [14:0] pc_out, link_pc;
  logic        fetch_valid, redirect_busy, halted;

  // Instance B: three bubble cycles
  logic        b_reset = 1'b1, b_fr = 1'b0, b_br = 1'b0, b_jr = 1'b0;
  logic [31:0] b_boff = '0, b_jt = '0;
  logic [14:0] b_pc, b_link_pc;
  logic        b_fv, b_rb, b_h;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .fetch_ready(fetch_ready),
    .branch_req(branch_req), .branch_offset(branch_offset),
    .jump_req(jump_req), .jump_target(jump_target),
    .halt_req(halt_req), .resume(resume),
`ifdef LINK_REG_EN
    .link_req(link_req), .link_pc(link_pc),
`endif
    .pc_out(pc_out), .fetch_valid(fetch_valid),
    .redirect_busy(redirect_busy), .halted(halted)
  );

  pc_sequencer #(.BUBBLE_CYCLES(3)) dut3 (
    .clk(clk), .reset(b_reset), .stall_i(1'b0), .fetch_ready(b_fr),
    .branch_req(b_br), .branch_offset(b_boff),
    .jump_req(b_jr), .jump_target(b_jt),
    .halt_req(1'b0), .resume(1'b0),
`ifdef LINK_REG_EN
    .link_req(1'b0), .link_pc(b_link_pc),
`endif
    .pc_out(b_pc), .fetch_valid(b_fv),
    .redirect_busy(b_rb), .halted(b_h)
  );

`ifndef LINK_REG_EN
  assign link_pc   = '0;
  assign b_link_pc = '0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vq[$];

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, stall, fr, br, input logic [31:0] boff,
                              input logic jr, input logic [31:0] jt, input logic hr, rs, lk,
                              input logic [14:0] pc, input logic fv, rb, h, input logic [14:0] link);
    vec_t v;
    v.rst = rst; v.stall = stall; v.fr = fr; v.br = br; v.boff = boff;
    v.jr = jr; v.jt = jt; v.hr = hr; v.rs = rs; v.lk = lk;
    v.pc = pc; v.fv = fv; v.rb = rb; v.h = h; v.link = link;
    return v;
  endfunction

  initial begin
    //                rst st fr br boff          jr jt            hr rs lk  pc        fv rb h  link
    vq.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 15'h0000, 0, 0, 0, 15'h0));
    vq.push_back(mk(1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 15'h0000, 0, 0, 0, 15'h0));
    vq.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 15'h0000, 1, 0, 0, 15'h0));
    vq.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 15'h0002, 1, 0, 0, 15'h0));
    vq.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 15'h0004, 1, 0, 0, 15'h0));
    vq.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 15'h0006, 1, 0, 0, 15'h0));
    vq.push_back(mk(0, 1, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 15'h0006, 1, 0, 0, 15'h0));
    vq.push_back(mk(0, 1, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 15'h0006, 1, 0, 0, 15'h0));
    vq.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 15'h0006, 1, 0, 0, 15'h0));
    vq.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 15'h0008, 1, 0, 0, 15'h0));
    vq.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 15'h000A, 1, 0, 0, 15'h0));
    vq.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 15'h000C, 1, 0, 0, 15'h0));
    vq.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 15'h000E, 1, 0, 0, 15'h0));
    vq.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 15'h0010, 1, 0, 0, 15'h0));
    vq.push_back(mk(0, 0, 1, 1, 32'hFFFFFFFC, 0, 32'h0,        0, 0, 0, 15'h0008, 0, 1, 0, 15'h0));
    vq.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 15'h0008, 1, 0, 0, 15'h0));
    vq.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 15'h000A, 1, 0, 0, 15'h0));
    vq.push_back(mk(0, 0, 1, 0, 32'h0,        1, 32'h10,       0, 0, 0, 15'h0020, 0, 1, 0, 15'h0));
    vq.push_back(mk(0, 0, 1, 1, 32'h8,        0, 32'h0,        0, 0, 0, 15'h0020, 1, 0, 0, 15'h0));
    vq.push_back(mk(0, 0, 1, 1, 32'h8,        1, 32'h40,       0, 0, 0, 15'h0080, 0, 1, 0, 15'h0));
    vq.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 15'h0080, 1, 0, 0, 15'h0));
    vq.push_back(mk(0, 0, 0, 0, 32'h0,        1, 32'h10,       0, 0, 0, 15'h0020, 0, 1, 0, 15'h0));
    vq.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 15'h0020, 1, 0, 0, 15'h0));
    vq.push_back(mk(0, 0, 0, 0, 32'h0,        1, 32'h40,       1, 0, 0, 15'h0020, 0, 0, 1, 15'h0));
    vq.push_back(mk(0, 0, 1, 0, 32'h0,        1, 32'h40,       0, 0, 0, 15'h0020, 0, 0, 1, 15'h0));
    vq.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 15'h0020, 1, 0, 0, 15'h0));
    vq.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 15'h0022, 1, 0, 0, 15'h0));
    vq.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 15'h0022, 1, 0, 0, 15'h0));
    vq.push_back(mk(0, 0, 0, 0, 32'h0,        1, 32'h3FFF,     0, 0, 0, 15'h7FFE, 0, 1, 0, 15'h0));
    vq.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 15'h7FFE, 1, 0, 0, 15'h0));
    vq.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 15'h0000, 1, 0, 0, 15'h0));
    vq.push_back(mk(0, 0, 0, 0, 32'h0,        1, 32'h100,      0, 0, 0, 15'h0200, 0, 1, 0, 15'h0));
    vq.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 15'h0000, 0, 0, 0, 15'h0));
    vq.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 15'h0000, 1, 0, 0, 15'h0));
    vq.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 15'h0002, 1, 0, 0, 15'h0));
    vq.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 15'h0002, 0, 0, 1, 15'h0));
    vq.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 15'h0000, 0, 0, 0, 15'h0));
    vq.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 15'h0000, 1, 0, 0, 15'h0));
    vq.push_back(mk(0, 0, 0, 0, 32'h0,        1, 32'h8,        0, 0, 0, 15'h0010, 0, 1, 0, 15'h0));
    vq.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 15'h0010, 0, 0, 1, 15'h0));
    vq.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 15'h0010, 1, 0, 0, 15'h0));
    vq.push_back(mk(0, 0, 0, 1, 32'hFFFFFFF0, 0, 32'h0,        0, 0, 0, 15'h7FF0, 0, 1, 0, 15'h0));
    vq.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 15'h7FF0, 1, 0, 0, 15'h0));
    vq.push_back(mk(0, 0, 0, 1, 32'h80000001, 0, 32'h0,        0, 0, 0, 15'h7FF2, 0, 1, 0, 15'h0));
    vq.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 15'h7FF2, 1, 0, 0, 15'h0));
    vq.push_back(mk(0, 0, 0, 0, 32'h0,        1, 32'h80,       0, 0, 0, 15'h0100, 0, 1, 0, 15'h0));
    vq.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 15'h0100, 1, 0, 0, 15'h0));
    vq.push_back(mk(0, 0, 0, 0, 32'h0,        1, 32'h10,       0, 0, 1, 15'h0020, 0, 1, 0, 15'h0102));
    vq.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 1, 15'h0020, 1, 0, 0, 15'h0102));
    vq.push_back(mk(0, 0, 0, 0, 32'h0,        1, 32'h0,        1, 0, 1, 15'h0020, 0, 0, 1, 15'h0102));
    vq.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 0, 15'h0020, 1, 0, 0, 15'h0102));

    @(negedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      reset = vq[i].rst; stall_i = vq[i].stall; fetch_ready = vq[i].fr;
      branch_req = vq[i].br; branch_offset = vq[i].boff;
      jump_req = vq[i].jr; jump_target = vq[i].jt;
      halt_req = vq[i].hr; resume = vq[i].rs; link_req = vq[i].lk;
      @(negedge clk);
      check("pc_out", i, 32'(pc_out), 32'(vq[i].pc));
      check("fetch_valid", i, 32'(fetch_valid), 32'(vq[i].fv));
      check("redirect_busy", i, 32'(redirect_busy), 32'(vq[i].rb));
      check("halted", i, 32'(halted), 32'(vq[i].h));
`ifdef LINK_REG_EN
      check("link_pc", i, 32'(link_pc), 32'(vq[i].link));
`endif
    end

    // Three-cycle bubble after a jump with truncated upper target bits
    b_reset = 1'b1;
    @(negedge clk);
    check("b_reset_pc", 0, 32'(b_pc), 32'h0);
    check("b_reset_fv", 0, 32'(b_fv), 32'h0);
    b_reset = 1'b0; b_fr = 1'b1;
    @(negedge clk);
    check("b_pc", 1, 32'(b_pc), 32'h2);
    b_jr = 1'b1; b_jt = 32'h00012345;
    @(negedge clk);
    check("b_jump_pc", 2, 32'(b_pc), 32'h468A);
    check("b_fv", 2, 32'(b_fv), 32'h0);
    check("b_rb", 2, 32'(b_rb), 32'h1);
    b_jr = 1'b0; b_br = 1'b1; b_boff = 32'h8;
    @(negedge clk);
    check("b_pc", 3, 32'(b_pc), 32'h468A);
    check("b_fv", 3, 32'(b_fv), 32'h0);
    b_br = 1'b0;
    @(negedge clk);
    check("b_pc", 4, 32'(b_pc), 32'h468A);
    check("b_fv", 4, 32'(b_fv), 32'h0);
    @(negedge clk);
    check("b_pc", 5, 32'(b_pc), 32'h468A);
    check("b_fv", 5, 32'(b_fv), 32'h1);
    check("b_rb", 5, 32'(b_rb), 32'h0);
    @(negedge clk);
    check("b_pc", 6, 32'(b_pc), 32'h468C);
    check("b_h", 6, 32'(b_h), 32'h0);
    check("b_link", 6, 32'(b_link_pc), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Owns the 15-bit program counter and sequences instruction fetch into instruction memory. Each cycle it selects the next PC from four sources: sequential increment, PC-relative branch, absolute jump, or hold. Branch and jump operands arrive as 32-bit word values; the block scales them by 2 and truncates them to PC width. After every redirect it inserts fetch bubbles, and it supports halt/resume from the control unit.

Parameters:
PC_WIDTH, 15, width of the PC and of the instruction memory address.
RESET_PC, 0, PC value loaded on reset.
PC_STEP, 2, sequential increment per accepted fetch.
BUBBLE_CYCLES, 1, fetch-invalid cycles after a redirect (legal range 1..7).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
stall_i  input  1  hazard stall; hold PC, fetch_valid stays as per state.
fetch_ready  input  1  imem accepts the address this cycle.
branch_req  input  1  taken branch resolved this cycle.
branch_offset  input  32  signed word offset, relative to current pc_out.
jump_req  input  1  absolute jump this cycle.
jump_target  input  32  word-index jump target.
halt_req  input  1  request halt.
resume  input  1  leave halt.
pc_out  output  PC_WIDTH  current fetch address.
fetch_valid  output  1  pc_out is a valid fetch request.
redirect_busy  output  1  high while in BUBBLE.
halted  output  1  high in HALT.

Behaviour:
- One clock and one reset. Reset is synchronous and active-high: on a clk edge with reset=1 the block loads pc_out=RESET_PC, state=RUN, bubble counter=0. During reset fetch_valid=0, redirect_busy=0 and halted=0. fetch_valid rises to 1 on the first cycle after reset deasserts.
- Reset takes effect mid-BUBBLE or mid-HALT with identical results.
- All outputs are registered or decoded from registered state. Input-to-pc_out latency is 1 cycle.
- States:
  - RUN: fetch_valid=1.
  - BUBBLE: fetch_valid=0, redirect_busy=1.
  - HALT: fetch_valid=0, halted=1.
- RUN priority, highest first:
  - halt_req: go to HALT, PC holds.
  - jump_req: pc_out <= (jump_target<<1)[PC_WIDTH-1:0]. Load the bubble counter with BUBBLE_CYCLES-1 and go to BUBBLE.
  - branch_req: pc_out <= (pc_out + (branch_offset<<1)[PC_WIDTH-1:0]) mod 2^PC_WIDTH. Load the counter and go to BUBBLE.
  - fetch_ready && !stall_i: pc_out <= (pc_out + PC_STEP) mod 2^PC_WIDTH.
  - Otherwise hold.
- Redirects are accepted regardless of stall_i and fetch_ready.
- Wrap: increment from 0x7FFE with step 2 gives 0x0000. Negative offsets wrap modulo 2^15. Upper bits of shifted operands are discarded silently.
- BUBBLE:
  - branch_req and jump_req are ignored.
  - halt_req goes to HALT and clears the counter.
  - Otherwise, if counter==0, go to RUN next cycle; else decrement.
  - Result: exactly BUBBLE_CYCLES cycles with fetch_valid=0.
- HALT:
  - pc_out holds and redirects are ignored.
  - resume goes to RUN next cycle.
  - halt_req with resume in the same cycle: resume wins.
  - resume while in RUN or BUBBLE is ignored.

Optional Feature:
LINK_REG_EN defined:
- Adds input link_req (1) and output link_pc (PC_WIDTH), reset 0.
- On an accepted jump_req with link_req=1 in RUN, link_pc <= pc_out + PC_STEP (mod 2^15).
- link_pc is unchanged otherwise.
LINK_REG_EN undefined:
- Neither port exists and no link register is built.

Test Plan:
- Reset held 2 cycles, release, fetch_ready=1 for 4 cycles: fetch_valid=0 during reset; then pc_out 0,2,4,6 with fetch_valid=1.
- At pc=0x0010, branch_req with branch_offset=0xFFFFFFFC (−4): next pc_out=0x0008. fetch_valid=0 for 1 cycle, redirect_busy=1; then 0x0008 and 0x000A.
- jump_target=0x00012345 with BUBBLE_CYCLES=3: pc_out=0x468A, fetch_valid low exactly 3 cycles. A branch_req during the bubble is ignored.
- pc=0x7FFE, fetch_ready=1: next pc_out=0x0000. stall_i=1 or fetch_ready=0 holds pc_out for as many cycles as asserted.
- jump_req and branch_req together at pc=0x0020, with jump_target=0x40 and offset=8: pc_out=0x0080 (jump wins). halt_req together with jump_req: HALT, pc_out holds 0x0020, halted=1; resume resumes fetch at 0x0020.
- Reset asserted mid-BUBBLE and mid-HALT: pc_out=RESET_PC and all flags low next cycle. With LINK_REG_EN, jump+link at pc=0x0100 gives link_pc=0x0102.
